// File: rtl/iob_uart16550_serial_rx_monitor.sv
// Serial-line receiver/checker for the uart16550 transmit pad.
// Decodes 16550-style frames (5..8 data bits, optional normal/stick parity,
// one checked stop bit) using 16x oversampling derived from a 16550 divisor,
// and queues each character with its parity/framing/break flags in a FIFO
// drained through a valid/ready handshake.
module iob_uart16550_serial_rx_monitor #(
    parameter int DIV_W       = 16,
    parameter int FIFO_ADDR_W = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cke_i,
    input  logic                   rxd_i,
    input  logic [DIV_W-1:0]       div_i,
    input  logic [5:0]             lcr_i,
    input  logic                   clear_i,
    output logic [7:0]             data_o,
    output logic                   perr_o,
    output logic                   ferr_o,
    output logic                   brk_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   overrun_o,
    output logic [FIFO_ADDR_W:0]   level_o
);

    localparam int DEPTH = 1 << FIFO_ADDR_W;
    localparam logic [DIV_W-1:0]       DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [FIFO_ADDR_W-1:0] PTR_ONE   = {{(FIFO_ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [FIFO_ADDR_W:0]   CNT_ONE   = {{FIFO_ADDR_W{1'b0}}, 1'b1};
    localparam logic [FIFO_ADDR_W:0]   DEPTH_CNT = {1'b1, {FIFO_ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    typedef struct packed {
        logic       brk;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rx_char_t;

    // ------------------------------------------------------------------
    // Synchronizer and edge detect
    // ------------------------------------------------------------------
    logic       sync1_q, sync2_q, prev_q;
    logic [1:0] prime_q;    // fills with ones once both sync flops hold real line samples

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its source; blocking here would collapse the chain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            prime_q <= 2'b00;
        end else if (cke_i) begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            prime_q <= {prime_q[0], 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Oversampling tick generator
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_q;
    logic             rx_en;
    logic             tick;
    logic             start_edge;
    state_t           state_q;
    logic             armed_q;

    assign rx_en = (div_i != '0);
    // '>=' keeps the counter bounded if div_i shrinks while running
    assign tick  = rx_en && (div_cnt_q >= div_i - DIV_ONE);
    assign start_edge = rx_en && (state_q == ST_IDLE) && armed_q && prev_q && !sync2_q;

    // Free-running divider, realigned to the start edge so samples land mid-bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
        end else if (cke_i) begin
            if (!rx_en || start_edge || tick) begin
                div_cnt_q <= '0;
            end else begin
                div_cnt_q <= div_cnt_q + DIV_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame decoder
    // ------------------------------------------------------------------
    logic [3:0] k_q;        // ticks within the current bit
    logic [2:0] bit_idx_q;
    logic [7:0] data_q;
    logic [5:0] lcr_q;
    logic       perr_q;
    logic       zero_q;     // every sample so far in this frame was 0
    logic [2:0] last_bit;
    logic       exp_par;
    logic       unused_stop2;

    // Only the first stop bit is checked; the two-stop setting only lengthens
    // the idle time the transmitter leaves, which edge re-arming already covers.
    assign unused_stop2 = lcr_q[2];

    assign last_bit = 3'd4 + {1'b0, lcr_q[1:0]};
    assign exp_par  = lcr_q[5] ? ~lcr_q[4] : (lcr_q[4] ? ^data_q : ~(^data_q));

    // Receive FSM: start qualification, data shift, parity and stop checks.
    // armed_q is cleared when a frame starts and set again only after the
    // line is seen high, so a held-low line (break, reset mid-frame) can never
    // look like a fresh start edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            lcr_q     <= '0;
            perr_q    <= 1'b0;
            zero_q    <= 1'b0;
            armed_q   <= 1'b0;
        end else if (cke_i) begin
            if (!rx_en) begin
                state_q <= ST_IDLE;
                k_q     <= '0;
                if (prime_q[1] && sync1_q && sync2_q) begin
                    armed_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        k_q <= '0;
                        if (start_edge) begin
                            state_q <= ST_START;
                            lcr_q   <= lcr_i;
                            armed_q <= 1'b0;
                        end else if (prime_q[1] && sync1_q && sync2_q) begin
                            armed_q <= 1'b1;
                        end
                    end
                    ST_START: begin
                        if (tick) begin
                            if (k_q == 4'd7) begin
                                k_q <= '0;
                                if (sync2_q) begin
                                    state_q <= ST_IDLE;     // glitch, not a start bit
                                end else begin
                                    state_q   <= ST_DATA;
                                    bit_idx_q <= '0;
                                    data_q    <= '0;
                                    perr_q    <= 1'b0;
                                    zero_q    <= 1'b1;
                                end
                            end else begin
                                k_q <= k_q + 4'd1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (tick) begin
                            if (k_q == 4'd15) begin
                                k_q               <= '0;
                                data_q[bit_idx_q] <= sync2_q;
                                if (sync2_q) begin
                                    zero_q <= 1'b0;
                                end
                                if (bit_idx_q == last_bit) begin
                                    state_q <= lcr_q[3] ? ST_PARITY : ST_STOP;
                                end else begin
                                    bit_idx_q <= bit_idx_q + 3'd1;
                                end
                            end else begin
                                k_q <= k_q + 4'd1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (tick) begin
                            if (k_q == 4'd15) begin
                                k_q     <= '0;
                                perr_q  <= (sync2_q != exp_par);
                                state_q <= ST_STOP;
                                if (sync2_q) begin
                                    zero_q <= 1'b0;
                                end
                            end else begin
                                k_q <= k_q + 4'd1;
                            end
                        end
                    end
                    ST_STOP: begin
                        if (tick) begin
                            if (k_q == 4'd15) begin
                                k_q     <= '0;
                                state_q <= ST_IDLE;
                            end else begin
                                k_q <= k_q + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        k_q     <= '0;
                    end
                endcase
            end
        end
    end

    // Character completes on the stop-bit sample tick.
    logic     push;
    rx_char_t push_char;

    assign push = cke_i && rx_en && (state_q == ST_STOP) && tick && (k_q == 4'd15);

    assign push_char.data = data_q;
    assign push_char.perr = perr_q;
    assign push_char.ferr = ~sync2_q;
    assign push_char.brk  = zero_q & ~sync2_q;

    // ------------------------------------------------------------------
    // Character FIFO
    // ------------------------------------------------------------------
    rx_char_t                 mem_q [DEPTH];
    logic [FIFO_ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FIFO_ADDR_W:0]     count_q;
    logic                     overrun_q;
    logic                     full;
    logic                     pop;
    logic                     wr_en;
    rx_char_t                 head;

    assign valid_o = (count_q != '0);
    assign full    = (count_q == DEPTH_CNT);
    assign pop     = cke_i && !clear_i && valid_o && ready_i;
    assign wr_en   = push && !rst_i && !clear_i && (!full || pop);

    // Storage write port.
    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define what is valid, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_char;
        end
    end

    // Pointers, occupancy and sticky overrun; clear takes priority over traffic.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else if (cke_i) begin
            if (clear_i) begin
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                count_q   <= '0;
                overrun_q <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                end
                if (wr_en && !pop) begin
                    count_q <= count_q + CNT_ONE;
                end else if (pop && !wr_en) begin
                    count_q <= count_q - CNT_ONE;
                end
                if (push && full && !pop) begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign overrun_o = overrun_q;
    assign level_o   = count_q;

    // Head-of-queue outputs, forced to zero while empty.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        data_o = '0;
        perr_o = 1'b0;
        ferr_o = 1'b0;
        brk_o  = 1'b0;
        if (valid_o) begin
            data_o = head.data;
            perr_o = head.perr;
            ferr_o = head.ferr;
            brk_o  = head.brk;
        end
    end

endmodule

// File: tb/tb_iob_uart16550_serial_rx_monitor.sv
// Directed bench for the UART serial receiver monitor: a table of framed
// characters with hand-computed results, plus sequences for latency, break,
// glitch rejection, reset mid-frame, clock enable and FIFO overrun/clear.
module tb_iob_uart16550_serial_rx_monitor;

    logic        clk = 1'b0;
    logic        rst, cke, rxd, clear, ready;
    logic [15:0] div;
    logic [5:0]  lcr;
    logic [7:0]  data_o;
    logic        perr_o, ferr_o, brk_o, valid_o, overrun_o;
    logic [4:0]  level_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    iob_uart16550_serial_rx_monitor #(.DIV_W(16), .FIFO_ADDR_W(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .cke_i     (cke),
        .rxd_i     (rxd),
        .div_i     (div),
        .lcr_i     (lcr),
        .clear_i   (clear),
        .data_o    (data_o),
        .perr_o    (perr_o),
        .ferr_o    (ferr_o),
        .brk_o     (brk_o),
        .valid_o   (valid_o),
        .ready_i   (ready),
        .overrun_o (overrun_o),
        .level_o   (level_o)
    );

    // {valid, brk, ferr, perr, data}
    typedef struct {
        int         dv;
        logic [5:0] lc;
        logic [7:0] din;
        int         nbits;
        bit         par_en;
        bit         par_bit;
        bit         stop_bit;
        logic [11:0] exp_head;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] head_now();
        return {valid_o, brk_o, ferr_o, perr_o, data_o};
    endfunction

    // Hold the line at v for n clocks; inputs change and outputs are read on negedges.
    task automatic line(input logic v, input int n);
        rxd = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                              input bit par_bit, input bit stop_bit, input int dv);
        line(1'b0, 16 * dv);
        for (int i = 0; i < nbits; i++) line(d[i], 16 * dv);
        if (par_en) line(par_bit, 16 * dv);
        line(stop_bit, 16 * dv);
        rxd = 1'b1;
    endtask

    task automatic pop_one();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 6'b000011, 8'h55, 8, 1'b0, 1'b0, 1'b1, 12'h855};  // 8N1
        vecs[1] = '{2, 6'b011010, 8'h41, 7, 1'b1, 1'b1, 1'b1, 12'h941};  // 7E1, bad parity
        vecs[2] = '{1, 6'b000011, 8'hA3, 8, 1'b0, 1'b0, 1'b0, 12'hAA3};  // stop low
        vecs[3] = '{1, 6'b001000, 8'hFB, 5, 1'b1, 1'b1, 1'b1, 12'h81B};  // 5O1, upper bits dropped
        vecs[4] = '{3, 6'b111001, 8'h2A, 6, 1'b1, 1'b0, 1'b1, 12'h82A};  // 6 bits, stick 0
        vecs[5] = '{1, 6'b101011, 8'hFF, 8, 1'b1, 1'b0, 1'b1, 12'h9FF};  // stick 1, sent 0
        vecs[6] = '{1, 6'b011011, 8'h00, 8, 1'b1, 1'b0, 1'b1, 12'h800};  // 8E1 zero data
        vecs[7] = '{2, 6'b000111, 8'h96, 8, 1'b0, 1'b0, 1'b1, 12'h896};  // 8N2
        vecs[8] = '{1, 6'b011011, 8'h00, 8, 1'b1, 1'b0, 1'b0, 12'hE00};  // all zero: break
        vecs[9] = '{1, 6'b001011, 8'h00, 8, 1'b1, 1'b1, 1'b0, 12'hA00};  // parity 1: no break

        rst = 1'b1; cke = 1'b1; rxd = 1'b1; clear = 1'b0; ready = 1'b0;
        div = 16'd1; lcr = 6'b000011;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_head", {20'h0, head_now()}, 32'h0);
        check("reset_level", {27'h0, level_o}, 32'd0);
        check("reset_overrun", {31'h0, overrun_o}, 32'd0);
        line(1'b1, 16);

        // Latency: 8N1 0x55 at div=1, timed from the falling start edge.
        line(1'b0, 16);
        for (int i = 0; i < 8; i++) line(i[0] ? 1'b0 : 1'b1, 16);
        line(1'b1, 6);
        check("latency_not_yet", {31'h0, valid_o}, 32'd0);
        line(1'b1, 10);
        check("latency_160", {20'h0, head_now()}, 32'h855);

        // Clock enable low freezes the FIFO even with ready high.
        cke = 1'b0; ready = 1'b1;
        repeat (4) @(negedge clk);
        ready = 1'b0; cke = 1'b1;
        check("cke_freeze_level", {27'h0, level_o}, 32'd1);
        pop_one();
        check("pop_level", {27'h0, level_o}, 32'd0);

        // Table of framings.
        for (int v = 0; v < 10; v++) begin
            div = vecs[v].dv[15:0];
            lcr = vecs[v].lc;
            line(1'b1, 8);
            send_frame(vecs[v].din, vecs[v].nbits, vecs[v].par_en, vecs[v].par_bit,
                       vecs[v].stop_bit, vecs[v].dv);
            line(1'b1, 32 * vecs[v].dv);
            check($sformatf("vec%0d_head", v), {20'h0, head_now()}, {20'h0, vecs[v].exp_head});
            check($sformatf("vec%0d_level", v), {27'h0, level_o}, 32'd1);
            pop_one();
        end

        // Break: line low 12 bit times yields exactly one entry.
        div = 16'd1; lcr = 6'b000011;
        line(1'b1, 16);
        line(1'b0, 180);
        check("break_head", {20'h0, head_now()}, 32'hE00);
        line(1'b0, 12);
        line(1'b1, 40);
        check("break_single", {27'h0, level_o}, 32'd1);
        pop_one();

        // Short low glitch is rejected, following frame is received.
        line(1'b0, 5);
        line(1'b1, 40);
        check("glitch_level", {27'h0, level_o}, 32'd0);
        check("glitch_valid", {31'h0, valid_o}, 32'd0);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1);
        line(1'b1, 32);
        check("after_glitch", {20'h0, head_now()}, 32'h8A5);
        pop_one();

        // Reset in the middle of data bit 6 of 0x3C (bits 6 and 7 are low).
        line(1'b0, 16);
        for (int i = 0; i < 6; i++) line((8'h3C >> i) & 8'h01 ? 1'b1 : 1'b0, 16);
        line(1'b0, 8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        line(1'b0, 7);
        line(1'b0, 16);
        line(1'b1, 16);
        line(1'b1, 32);
        check("rst_mid_level", {27'h0, level_o}, 32'd0);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1);
        line(1'b1, 32);
        check("rst_next_level", {27'h0, level_o}, 32'd1);
        check("rst_next_head", {20'h0, head_now()}, 32'h8C3);
        pop_one();

        // Overrun: 17 characters into a 16-deep FIFO.
        for (int c = 0; c < 17; c++) begin
            send_frame(c[7:0], 8, 1'b0, 1'b0, 1'b1, 1);
            line(1'b1, 16);
        end
        check("full_level", {27'h0, level_o}, 32'd16);
        check("overrun_set", {31'h0, overrun_o}, 32'd1);
        for (int c = 0; c < 16; c++) begin
            check($sformatf("drain%0d", c), {20'h0, head_now()}, 32'h800 | c);
            pop_one();
        end
        check("drained_level", {27'h0, level_o}, 32'd0);
        check("overrun_sticky", {31'h0, overrun_o}, 32'd1);
        send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1, 1);
        line(1'b1, 32);
        check("pre_clear_level", {27'h0, level_o}, 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_level", {27'h0, level_o}, 32'd0);
        check("clear_overrun", {31'h0, overrun_o}, 32'd0);
        check("clear_valid", {31'h0, valid_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
